// File: rtl/bp_fe_bp_resolve_tracker.sv
// bp_fe_bp_resolve_tracker
//
// Update-side tracker for the two-level local branch predictor. It forwards
// fetch's prediction reads to the predictor and remembers each accepted read
// as {idx, predicted direction} in an in-order in-flight queue. When the
// oldest branch resolves, it compares the actual direction against the
// recorded prediction and drives the predictor update port one cycle later.
// It also keeps saturating resolved/mispredict counters and a sticky error
// flag for resolves that arrive with nothing in flight.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-low reset
//   fetch_v_i/_idx_i      fetch prediction request and branch index
//   fetch_ready_o         queue can take a request this cycle
//   fetch_taken_o         prediction returned to fetch (same cycle)
//   r_v_o/idx_r_o         predictor read port
//   predict_i             predictor read data (combinational from idx_r_o)
//   res_v_i/res_taken_i   oldest in-flight branch resolves, actual direction
//   flush_i               discard all in-flight entries
//   w_v_o/idx_w_o         predictor update valid and index
//   correct_o             recorded prediction matched actual direction
//   count_o               number of in-flight entries
//   resolved_cnt_o        saturating count of processed resolves
//   mispredict_cnt_o      saturating count of resolves with correct_o = 0
//   error_o               sticky: resolve seen while queue empty
//
// Handshake: a fetch request is accepted exactly in a cycle where
// fetch_v_i & fetch_ready_o; fetch_ready_o never depends on fetch_v_i, and
// the predictor read (r_v_o) is issued only for accepted requests. There is
// no backpressure on resolves: res_v_i is a single-cycle event that pops the
// head entry if one exists.

module bp_fe_bp_resolve_tracker #(
  parameter int bht_idx_width_p = 2,
  parameter int els_p           = 4,
  parameter int cnt_width_p     = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          fetch_v_i,
  input  logic [bht_idx_width_p-1:0]    fetch_idx_i,
  output logic                          fetch_ready_o,
  output logic                          fetch_taken_o,
  output logic                          r_v_o,
  output logic [bht_idx_width_p-1:0]    idx_r_o,
  input  logic                          predict_i,
  input  logic                          res_v_i,
  input  logic                          res_taken_i,
  input  logic                          flush_i,
  output logic                          w_v_o,
  output logic [bht_idx_width_p-1:0]    idx_w_o,
  output logic                          correct_o,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic [cnt_width_p-1:0]        resolved_cnt_o,
  output logic [cnt_width_p-1:0]        mispredict_cnt_o,
  output logic                          error_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

  // In-flight storage; contents need no reset because count/pointers do.
  logic [bht_idx_width_p-1:0] idx_mem_q   [els_p];
  logic                       taken_mem_q [els_p];

  logic [ptr_w_lp-1:0]        head_q, head_d;
  logic [ptr_w_lp-1:0]        tail_q, tail_d;
  logic [cnt_w_lp-1:0]        count_q, count_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic [cnt_width_p-1:0]     res_cnt_q, res_cnt_d;
  logic [cnt_width_p-1:0]     mis_cnt_q, mis_cnt_d;
  logic                       err_q, err_d;

  logic accept;
  logic res_ok;
  logic res_empty;
  logic correct_now;

  // Read path. Full blocks enqueue even when a resolve frees a slot in the
  // same cycle, which keeps fetch_ready_o independent of res_v_i.
  assign fetch_ready_o = (count_q != full_lp) & ~flush_i;
  assign accept        = fetch_v_i & fetch_ready_o;
  assign r_v_o         = accept;
  assign idx_r_o       = fetch_idx_i;
  assign fetch_taken_o = predict_i;

  // A resolve only counts when something is in flight; an enqueue in the
  // same cycle is not visible to it.
  assign res_ok      = res_v_i & (count_q != '0);
  assign res_empty   = res_v_i & (count_q == '0);
  assign correct_now = (taken_mem_q[head_q] == res_taken_i);

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    w_v_d     = res_ok;
    idx_w_d   = idx_w_q;
    correct_d = correct_q;
    res_cnt_d = res_cnt_q;
    mis_cnt_d = mis_cnt_q;
    err_d     = err_q | res_empty;

    if (res_ok) begin
      idx_w_d   = idx_mem_q[head_q];
      correct_d = correct_now;
      if (res_cnt_q != '1) res_cnt_d = res_cnt_q + cnt_width_p'(1);
      if (!correct_now && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + cnt_width_p'(1);
    end

    if (flush_i) begin
      // The same-cycle resolve above is still reported; the queue empties.
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (accept) tail_d = tail_q + ptr_w_lp'(1);
      if (res_ok) head_d = head_q + ptr_w_lp'(1);
      case ({accept, res_ok})
        2'b10:   count_d = count_q + cnt_w_lp'(1);
        2'b01:   count_d = count_q - cnt_w_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      w_v_q     <= 1'b0;
      idx_w_q   <= '0;
      correct_q <= 1'b0;
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      w_v_q     <= w_v_d;
      idx_w_q   <= idx_w_d;
      correct_q <= correct_d;
      res_cnt_q <= res_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i && accept) begin
      idx_mem_q[tail_q]   <= fetch_idx_i;
      taken_mem_q[tail_q] <= predict_i;
    end
  end

  assign w_v_o            = w_v_q;
  assign idx_w_o          = idx_w_q;
  assign correct_o        = correct_q;
  assign count_o          = count_q;
  assign resolved_cnt_o   = res_cnt_q;
  assign mispredict_cnt_o = mis_cnt_q;
  assign error_o          = err_q;

endmodule

// File: tb/tb_bp_fe_bp_resolve_tracker.sv
// Testbench for bp_fe_bp_resolve_tracker (els_p = 4, 4-bit counters so that
// saturation is reachable quickly). Each cycle is driven after the falling
// edge; combinational outputs are checked before the rising edge and
// registered outputs 1 time unit after it.

module tb_bp_fe_bp_resolve_tracker;

  localparam int IW   = 2;
  localparam int ELS  = 4;
  localparam int CW   = 4;
  localparam int CNTW = $clog2(ELS+1);
  localparam int CMAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_i;
  logic            fetch_v_i;
  logic [IW-1:0]   fetch_idx_i;
  logic            fetch_ready_o;
  logic            fetch_taken_o;
  logic            r_v_o;
  logic [IW-1:0]   idx_r_o;
  logic            predict_i;
  logic            res_v_i;
  logic            res_taken_i;
  logic            flush_i;
  logic            w_v_o;
  logic [IW-1:0]   idx_w_o;
  logic            correct_o;
  logic [CNTW-1:0] count_o;
  logic [CW-1:0]   resolved_cnt_o;
  logic [CW-1:0]   mispredict_cnt_o;
  logic            error_o;

  bp_fe_bp_resolve_tracker #(
    .bht_idx_width_p (IW),
    .els_p           (ELS),
    .cnt_width_p     (CW)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fetch_v_i        (fetch_v_i),
    .fetch_idx_i      (fetch_idx_i),
    .fetch_ready_o    (fetch_ready_o),
    .fetch_taken_o    (fetch_taken_o),
    .r_v_o            (r_v_o),
    .idx_r_o          (idx_r_o),
    .predict_i        (predict_i),
    .res_v_i          (res_v_i),
    .res_taken_i      (res_taken_i),
    .flush_i          (flush_i),
    .w_v_o            (w_v_o),
    .idx_w_o          (idx_w_o),
    .correct_o        (correct_o),
    .count_o          (count_o),
    .resolved_cnt_o   (resolved_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o),
    .error_o          (error_o)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [IW:0] ent_q[$];   // model in-flight queue: {idx, predicted}
  logic [IW:0] exp_q[$];   // expected updates: {idx, correct}
  int          m_res;
  int          m_mis;
  logic        m_err;
  logic [IW-1:0] last_idx;
  logic        last_corr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    ent_q.delete();
    exp_q.delete();
    m_res     = 0;
    m_mis     = 0;
    m_err     = 1'b0;
    last_idx  = '0;
    last_corr = 1'b0;
  endtask

  // Reset for one edge; with busy = 1 fetch and resolve are active during it.
  task automatic do_reset(input bit busy);
    reset_i     = 1'b0;
    fetch_v_i   = busy;
    fetch_idx_i = 2'd1;
    predict_i   = 1'b1;
    res_v_i     = busy;
    res_taken_i = 1'b0;
    flush_i     = 1'b0;
    @(posedge clk); #1;
    model_clear();
    chk("rst_count", count_o, 0);
    chk("rst_w_v", w_v_o, 0);
    chk("rst_idx_w", idx_w_o, 0);
    chk("rst_correct", correct_o, 0);
    chk("rst_resolved", resolved_cnt_o, 0);
    chk("rst_mispred", mispredict_cnt_o, 0);
    chk("rst_error", error_o, 0);
    @(negedge clk);
    reset_i   = 1'b1;
    fetch_v_i = 1'b0;
    res_v_i   = 1'b0;
    #1;
    chk("rst_ready", fetch_ready_o, 1);
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit fv, input logic [IW-1:0] idx, input bit pred,
                       input bit rv, input bit rt, input bit fl);
    bit          ready_e, acc, exp_w, corr;
    logic [IW:0] e, u;
    fetch_v_i   = fv;
    fetch_idx_i = idx;
    predict_i   = pred;
    res_v_i     = rv;
    res_taken_i = rt;
    flush_i     = fl;
    #1;
    ready_e = (ent_q.size() != ELS) && !fl;
    acc     = fv && ready_e;
    chk("fetch_ready", fetch_ready_o, ready_e);
    chk("r_v", r_v_o, acc);
    chk("fetch_taken", fetch_taken_o, pred);
    chk("idx_r", idx_r_o, idx);

    exp_w = 1'b0;
    if (rv) begin
      if (ent_q.size() > 0) begin
        e    = ent_q.pop_front();
        corr = (e[0] == rt);
        exp_q.push_back({e[IW:1], corr});
        m_res = (m_res == CMAX) ? CMAX : m_res + 1;
        if (!corr) m_mis = (m_mis == CMAX) ? CMAX : m_mis + 1;
        exp_w = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (fl) ent_q.delete();
    else if (acc) ent_q.push_back({idx, pred});

    @(posedge clk); #1;
    chk("w_v", w_v_o, exp_w);
    if (w_v_o) begin
      if (exp_q.size() == 0) begin
        chk("upd_expected", 0, 1);
      end else begin
        u = exp_q.pop_front();
        chk("idx_w", idx_w_o, u[IW:1]);
        chk("correct", correct_o, u[0]);
        last_idx  = u[IW:1];
        last_corr = u[0];
      end
    end else begin
      chk("idx_w_hold", idx_w_o, last_idx);
      chk("correct_hold", correct_o, last_corr);
    end
    chk("count", count_o, ent_q.size());
    chk("resolved_cnt", resolved_cnt_o, m_res);
    chk("mispredict_cnt", mispredict_cnt_o, m_mis);
    chk("error", error_o, m_err);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            fv;
    logic [IW-1:0] idx;
    bit            pred;
    bit            rv;
    bit            rt;
    bit            fl;
    int            exp_cnt;
    bit            exp_w;
    logic [IW-1:0] exp_widx;
    bit            exp_corr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 2'd1, 1, 0, 0, 0, 1, 0, 2'd0, 0};
    vecs[1] = '{1, 2'd2, 0, 0, 0, 0, 2, 0, 2'd0, 0};
    vecs[2] = '{1, 2'd3, 1, 0, 0, 0, 3, 0, 2'd0, 0};
    vecs[3] = '{0, 2'd0, 0, 1, 1, 0, 2, 1, 2'd1, 1};
    vecs[4] = '{0, 2'd0, 0, 1, 1, 0, 1, 1, 2'd2, 0};
    vecs[5] = '{0, 2'd0, 0, 1, 1, 0, 0, 1, 2'd3, 1};

    model_clear();
    do_reset(1'b0);

    // Enqueue 1/2/3 then resolve three times, taken every time.
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].fv, vecs[i].idx, vecs[i].pred, vecs[i].rv, vecs[i].rt, vecs[i].fl);
      chk("tbl_count", count_o, vecs[i].exp_cnt);
      chk("tbl_w_v", w_v_o, vecs[i].exp_w);
      if (vecs[i].exp_w) begin
        chk("tbl_idx_w", idx_w_o, vecs[i].exp_widx);
        chk("tbl_correct", correct_o, vecs[i].exp_corr);
      end
    end
    chk("tbl_resolved", resolved_cnt_o, 3);
    chk("tbl_mispred", mispredict_cnt_o, 1);

    // Fill, blocked fetch, resolve+fetch while full, then wrap-around.
    do_reset(1'b0);
    for (int i = 0; i < ELS; i++) cycle(1, IW'(i), 1'($urandom_range(0, 1)), 0, 0, 0);
    cycle(1, 2'd2, 1, 0, 0, 0);
    chk("full_ready", fetch_ready_o, 1'b0);
    cycle(1, 2'd1, 0, 1, 1'($urandom_range(0, 1)), 0);
    chk("full_resolve_count", count_o, 3);
    cycle(1, 2'd1, 0, 0, 0, 0);
    chk("refill_count", count_o, 4);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 2'd0, 0, 1, 1'($urandom_range(0, 1)), 0);
      cycle(1, IW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, 0);
    end
    for (int i = 0; i < ELS; i++) cycle(0, 2'd0, 0, 1, 1'($urandom_range(0, 1)), 0);
    chk("drain_count", count_o, 0);

    // Flush with three entries and a same-cycle resolve.
    do_reset(1'b0);
    cycle(1, 2'd2, 1, 0, 0, 0);
    cycle(1, 2'd3, 0, 0, 0, 0);
    cycle(1, 2'd0, 1, 0, 0, 0);
    cycle(1, 2'd3, 1, 1, 0, 1);
    chk("flush_w_v", w_v_o, 1);
    chk("flush_idx_w", idx_w_o, 2);
    chk("flush_correct", correct_o, 0);
    chk("flush_count", count_o, 0);
    cycle(0, 2'd0, 0, 1, 1, 0);
    chk("flush_then_err", error_o, 1);

    // Resolve on empty with same-cycle enqueue.
    do_reset(1'b0);
    cycle(1, 2'd2, 1, 1, 1, 0);
    chk("empty_err", error_o, 1);
    chk("empty_w_v", w_v_o, 0);
    chk("empty_count", count_o, 1);

    // Counter saturation, then reset with traffic in flight.
    do_reset(1'b0);
    cycle(1, 2'd1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(1, 2'd1, 1, 1, 0, 0);
    chk("sat_resolved", resolved_cnt_o, 15);
    chk("sat_mispred", mispredict_cnt_o, 15);
    do_reset(1'b1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_fe_bp_resolve_tracker.md
Name: bp_fe_bp_resolve_tracker

Overview:
- Back end of the two-level local predictor's update interface.
- Issues predictor reads on behalf of fetch and records each read's {idx, predicted direction} in an in-order in-flight queue.
- When the branch resolves, compares the actual outcome with the recorded prediction and drives the predictor's update port (w_v/idx_w/correct) one cycle later.
- Keeps saturating resolved/mispredict statistics and a sticky protocol-error flag.

Parameters:
- bht_idx_width_p, 2, width of the BHT index on the read and update ports.
- els_p, 4, in-flight queue depth; power of 2, ≥2.
- cnt_width_p, 16, width of the saturating statistics counters.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset.
- fetch_v_i  in  1  fetch requests a prediction.
- fetch_idx_i  in  bht_idx_width_p  branch index.
- fetch_ready_o  out  1  queue can accept; a request is accepted when fetch_v_i & fetch_ready_o.
- fetch_taken_o  out  1  prediction returned to fetch, same cycle as acceptance.
- r_v_o  out  1  predictor read valid.
- idx_r_o  out  bht_idx_width_p  predictor read index.
- predict_i  in  1  predictor read result; combinational from idx_r_o.
- res_v_i  in  1  oldest in-flight branch resolves this cycle.
- res_taken_i  in  1  actual direction.
- flush_i  in  1  discard all in-flight entries.
- w_v_o  out  1  predictor update valid.
- idx_w_o  out  bht_idx_width_p  update index.
- correct_o  out  1  1 when the recorded prediction equals res_taken_i.
- count_o  out  $clog2(els_p+1)  number of in-flight entries.
- resolved_cnt_o  out  cnt_width_p  resolves processed.
- mispredict_cnt_o  out  cnt_width_p  resolves with correct = 0.
- error_o  out  1  sticky: res_v_i seen while queue empty.

Behaviour:
- Reset (reset_i = 0 at posedge):
  - Pointers, count_o, w_v_o, idx_w_o, correct_o, both counters and error_o all go to 0.
  - fetch_ready_o reads 1 from the first cycle after reset.
  - Reset mid-operation drops all entries and any pending update (w_v_o = 0 next cycle).
- Read path (combinational):
  - fetch_ready_o = (count_o != els_p) & ~flush_i.
  - r_v_o = fetch_v_i & fetch_ready_o; idx_r_o = fetch_idx_i; fetch_taken_o = predict_i.
- Enqueue:
  - On acceptance, entry {fetch_idx_i, predict_i} is written at the tail at the clock edge; the tail pointer wraps modulo els_p.
  - Full blocks enqueue even if a resolve dequeues in the same cycle.
- Resolve:
  - res_v_i with count_o > 0 pops the head entry.
  - Next cycle: w_v_o = 1, idx_w_o = entry idx, correct_o = (entry taken == res_taken_i).
  - Update latency is exactly 1 cycle; w_v_o is a 1-cycle pulse per resolve.
  - Back-to-back resolves give back-to-back pulses.
  - idx_w_o and correct_o hold their last values when w_v_o = 0.
- Resolve on empty:
  - res_v_i with count_o == 0 sets error_o (sticky until reset).
  - No update, no counter change.
  - An enqueue in the same cycle does not satisfy the resolve.
- Simultaneous enqueue and resolve (non-empty, non-full): both happen and count_o is unchanged.
- Flush:
  - flush_i clears head, tail and count at the edge.
  - A res_v_i in the same cycle is processed first (the update still issues).
  - Enqueue is blocked in the flush cycle.
- Counters:
  - resolved_cnt_o increments per processed resolve; mispredict_cnt_o increments when the computed correct = 0.
  - Both saturate at all-ones and do not wrap.
- Invariant: 0 ≤ count_o ≤ els_p at all times.

Test Plan:
- Reset, then enqueue idx 1/2/3 with predict_i = 1/0/1 -> count_o = 3, fetch_taken_o mirrors predict_i, r_v_o asserted each cycle.
- Resolve taken = 1,1,1 on three consecutive cycles -> w_v_o pulses on cycles +1..+3 with idx_w_o = 1,2,3 and correct_o = 1,0,1; mispredict_cnt_o = 1, resolved_cnt_o = 3.
- Fill to els_p = 4 -> fetch_ready_o = 0, r_v_o = 0 with fetch_v_i held. Then resolve plus fetch in the same cycle -> no enqueue that cycle, count_o = 3; enqueue succeeds the next cycle. Repeat past 8 entries -> wrap-around preserves FIFO order.
- Flush with 3 entries plus same-cycle resolve -> one update for the head entry, count_o = 0 next cycle, a following resolve sets error_o = 1.
- Resolve on empty with a same-cycle enqueue -> error_o = 1, w_v_o stays 0, count_o = 1.
- Preload counters near saturation (cnt_width_p = 4, 20 mispredicting resolves) -> both counters stick at 15; reset_i low mid-stream -> all outputs 0 next cycle.
